// File: rtl/if_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: hazard/IFID op codes,
// next-PC select codes, fetch FSM states and the bubble instruction word.
package if_stage_pkg;

   localparam logic [1:0] IFOP_NORMAL = 2'd0;
   localparam logic [1:0] IFOP_FLUSH  = 2'd1;
   localparam logic [1:0] IFOP_STALL  = 2'd2;

   localparam logic [1:0] PCSRC_SEQ = 2'd0;
   localparam logic [1:0] PCSRC_BR  = 2'd1;
   localparam logic [1:0] PCSRC_J   = 2'd2;
   localparam logic [1:0] PCSRC_JR  = 2'd3;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_DROP = 2'd1,
      S_FULL = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory req/ack port; the fetch stage is master, memory is slave.
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage_next_pc.sv
// Redirect decode and target mux for the fetch stage. With IF_EXC_EN defined,
// also flags redirect targets that are not word aligned.
module if_next_pc
   import if_stage_pkg::*;
(
   input  logic [1:0]  pc_src,
   input  logic        comp_true,
   input  logic [31:0] branch_pc,
   input  logic [31:0] j_pc,
   input  logic [31:0] jr_pc,
   output logic        redirect,
   output logic [31:0] target,
   output logic        misaligned
);

   always_comb begin
      redirect = 1'b0;
      target   = branch_pc;
      case (pc_src)
         PCSRC_BR: begin
            redirect = comp_true;
            target   = branch_pc;
         end
         PCSRC_J: begin
            redirect = 1'b1;
            target   = j_pc;
         end
         PCSRC_JR: begin
            redirect = 1'b1;
            target   = jr_pc;
         end
         default: begin
            redirect = 1'b0;
            target   = branch_pc;
         end
      endcase
   end

`ifdef IF_EXC_EN
   assign misaligned = redirect && (target[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, variable-latency imem fetch FSM, skid
// buffer and IF/ID register. Optional misaligned-redirect trap via IF_EXC_EN.
//
// state  | meaning
// S_REQ  | request outstanding at PC, data usable when ack arrives
// S_DROP | request to a stale address outstanding, its data is discarded
// S_FULL | no request, one fetched instruction for PC held in buf_instr
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = NOP_WORD,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0004
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        IFIDop,
   input  logic [1:0]        PCSrc,
   input  logic              comp_true,
   input  logic [31:0]       branchPC,
   input  logic [31:0]       jPC,
   input  logic [31:0]       jrPC,
   if_stage_if.master        imem,
   output logic [31:0]       IFID_PCplus4,
   output logic [31:0]       IFID_Instruction,
   output logic              fetch_pending,
   output logic              if_exception
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  addr_q;
   logic [31:0]  buf_instr;

   logic         redirect;
   logic         misaligned;
   logic [31:0]  target;
   logic [31:0]  redir_pc;
   logic         stall;
   logic         take_redirect;
   logic         avail;
   logic [31:0]  instr;
   logic [31:0]  pc_plus4;

   if_next_pc u_next_pc (
      .pc_src     (PCSrc),
      .comp_true  (comp_true),
      .branch_pc  (branchPC),
      .j_pc       (jPC),
      .jr_pc      (jrPC),
      .redirect   (redirect),
      .target     (target),
      .misaligned (misaligned)
   );

   assign stall         = IFIDop[1];
   assign take_redirect = redirect && !stall;
   assign redir_pc      = misaligned ? EXC_VECTOR : target;
   assign avail         = ((state == S_REQ) && imem.imem_ack) || (state == S_FULL);
   assign instr         = (state == S_FULL) ? buf_instr : imem.imem_rdata;
   assign pc_plus4      = pc + 32'd4;

   // addr_q only moves when a new request starts, so it is stable under req
   assign imem.imem_req  = (state != S_FULL);
   assign imem.imem_addr = addr_q;
   assign fetch_pending  = (state == S_REQ) || (state == S_DROP);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_REQ;
         pc               <= RESET_PC;
         addr_q           <= RESET_PC;
         buf_instr        <= NOP_INSTR;
         IFID_PCplus4     <= '0;
         IFID_Instruction <= NOP_INSTR;
         if_exception     <= 1'b0;
      end else begin
         if_exception <= take_redirect && misaligned;
         if (take_redirect) begin
            pc               <= redir_pc;
            IFID_PCplus4     <= '0;
            IFID_Instruction <= NOP_INSTR;
            // an outstanding request cannot be aborted; wait out its ack
            if ((state != S_FULL) && !imem.imem_ack) begin
               state <= S_DROP;
            end else begin
               state  <= S_REQ;
               addr_q <= redir_pc;
            end
         end else if ((IFIDop == IFOP_NORMAL) && avail) begin
            IFID_PCplus4     <= pc_plus4;
            IFID_Instruction <= instr;
            pc               <= pc_plus4;
            addr_q           <= pc_plus4;
            state            <= S_REQ;
         end else begin
            if (!stall) begin
               IFID_PCplus4     <= '0;
               IFID_Instruction <= NOP_INSTR;
            end
            if ((state == S_REQ) && imem.imem_ack) begin
               buf_instr <= imem.imem_rdata;
               state     <= S_FULL;
            end else if ((state == S_DROP) && imem.imem_ack) begin
               state  <= S_REQ;
               addr_q <= pc;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: memory is driven by hand, cycle by cycle.
module tb_if_stage;
   import if_stage_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [1:0]  IFIDop;
   logic [1:0]  PCSrc;
   logic        comp_true;
   logic [31:0] branchPC;
   logic [31:0] jPC;
   logic [31:0] jrPC;
   logic [31:0] IFID_PCplus4;
   logic [31:0] IFID_Instruction;
   logic        fetch_pending;
   logic        if_exception;

   int n_checks = 0;
   int n_fail   = 0;

   if_stage_if mem ();

   if_stage dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .IFIDop           (IFIDop),
      .PCSrc            (PCSrc),
      .comp_true        (comp_true),
      .branchPC         (branchPC),
      .jPC              (jPC),
      .jrPC             (jrPC),
      .imem             (mem),
      .IFID_PCplus4     (IFID_PCplus4),
      .IFID_Instruction (IFID_Instruction),
      .fetch_pending    (fetch_pending),
      .if_exception     (if_exception)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_checks++; if (IFID_PCplus4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4 got=%h exp=%h", IFID_PCplus4, 32'h0); end
      n_checks++; if (IFID_Instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr got=%h exp=%h", IFID_Instruction, 32'h0); end
      n_checks++; if (if_exception !== 1'b0) begin n_fail++; $display("FAIL rst_exc got=%b exp=0", if_exception); end
      reset_n = 1'b1;
      n_checks++; if (mem.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req got=%b exp=1", mem.imem_req); end
      n_checks++; if (mem.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=%h", mem.imem_addr, 32'h0); end
      n_checks++; if (fetch_pending !== 1'b1) begin n_fail++; $display("FAIL rst_pending got=%b exp=1", fetch_pending); end
   endtask

   task automatic test_sequential();
      mem.imem_ack = 1'b1; mem.imem_rdata = 32'h2008_0001;
      tick();
      n_checks++; if (IFID_PCplus4 !== 32'h4) begin n_fail++; $display("FAIL seq1_pc4 got=%h exp=%h", IFID_PCplus4, 32'h4); end
      n_checks++; if (IFID_Instruction !== 32'h2008_0001) begin n_fail++; $display("FAIL seq1_instr got=%h exp=%h", IFID_Instruction, 32'h2008_0001); end
      n_checks++; if (mem.imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq1_addr got=%h exp=%h", mem.imem_addr, 32'h4); end
      mem.imem_rdata = 32'h2009_0002;
      tick();
      n_checks++; if (IFID_PCplus4 !== 32'h8) begin n_fail++; $display("FAIL seq2_pc4 got=%h exp=%h", IFID_PCplus4, 32'h8); end
      n_checks++; if (IFID_Instruction !== 32'h2009_0002) begin n_fail++; $display("FAIL seq2_instr got=%h exp=%h", IFID_Instruction, 32'h2009_0002); end
      n_checks++; if (mem.imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq2_addr got=%h exp=%h", mem.imem_addr, 32'h8); end
   endtask

   task automatic test_stall();
      IFIDop = IFOP_STALL; mem.imem_ack = 1'b1; mem.imem_rdata = 32'hAAAA_0000;
      tick();
      mem.imem_ack = 1'b0;
      n_checks++; if (IFID_Instruction !== 32'h2009_0002) begin n_fail++; $display("FAIL stall_hold_instr got=%h exp=%h", IFID_Instruction, 32'h2009_0002); end
      n_checks++; if (mem.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got=%b exp=0", mem.imem_req); end
      n_checks++; if (fetch_pending !== 1'b0) begin n_fail++; $display("FAIL stall_pending got=%b exp=0", fetch_pending); end
      tick();
      tick();
      n_checks++; if (IFID_PCplus4 !== 32'h8) begin n_fail++; $display("FAIL stall3_pc4 got=%h exp=%h", IFID_PCplus4, 32'h8); end
      n_checks++; if (mem.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall3_req got=%b exp=0", mem.imem_req); end
      IFIDop = IFOP_NORMAL;
      tick();
      n_checks++; if (IFID_PCplus4 !== 32'hC) begin n_fail++; $display("FAIL unstall_pc4 got=%h exp=%h", IFID_PCplus4, 32'hC); end
      n_checks++; if (IFID_Instruction !== 32'hAAAA_0000) begin n_fail++; $display("FAIL unstall_instr got=%h exp=%h", IFID_Instruction, 32'hAAAA_0000); end
      n_checks++; if (mem.imem_addr !== 32'hC || mem.imem_req !== 1'b1) begin n_fail++; $display("FAIL unstall_addr got=%h/%b exp=%h/1", mem.imem_addr, mem.imem_req, 32'hC); end
   endtask

   task automatic test_branch();
      PCSrc = PCSRC_BR; comp_true = 1'b1; branchPC = 32'h40;
      mem.imem_ack = 1'b1; mem.imem_rdata = 32'h1111_1111;
      tick();
      n_checks++; if (IFID_Instruction !== 32'h0 || IFID_PCplus4 !== 32'h0) begin n_fail++; $display("FAIL br_bubble got=%h/%h exp=0/0", IFID_PCplus4, IFID_Instruction); end
      n_checks++; if (mem.imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_addr got=%h exp=%h", mem.imem_addr, 32'h40); end
      comp_true = 1'b0; mem.imem_rdata = 32'h2222_2222;
      tick();
      n_checks++; if (IFID_PCplus4 !== 32'h44 || IFID_Instruction !== 32'h2222_2222) begin n_fail++; $display("FAIL br_nt_ifid got=%h/%h exp=%h/%h", IFID_PCplus4, IFID_Instruction, 32'h44, 32'h2222_2222); end
      n_checks++; if (mem.imem_addr !== 32'h44) begin n_fail++; $display("FAIL br_nt_addr got=%h exp=%h", mem.imem_addr, 32'h44); end
      PCSrc = PCSRC_SEQ; mem.imem_ack = 1'b0;
      tick();
      n_checks++; if (IFID_Instruction !== 32'h0 || mem.imem_req !== 1'b1) begin n_fail++; $display("FAIL noack_bubble got=%h/%b exp=0/1", IFID_Instruction, mem.imem_req); end
   endtask

   task automatic test_flush();
      mem.imem_ack = 1'b1; mem.imem_rdata = 32'h4444_4444;
      tick();
      n_checks++; if (IFID_PCplus4 !== 32'h48 || IFID_Instruction !== 32'h4444_4444) begin n_fail++; $display("FAIL pre_flush_ifid got=%h/%h exp=%h/%h", IFID_PCplus4, IFID_Instruction, 32'h48, 32'h4444_4444); end
      IFIDop = IFOP_FLUSH; mem.imem_rdata = 32'h3333_3333;
      tick();
      mem.imem_ack = 1'b0;
      n_checks++; if (IFID_PCplus4 !== 32'h0 || IFID_Instruction !== 32'h0) begin n_fail++; $display("FAIL flush_bubble got=%h/%h exp=0/0", IFID_PCplus4, IFID_Instruction); end
      n_checks++; if (mem.imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_keep_req got=%b exp=0", mem.imem_req); end
      IFIDop = IFOP_NORMAL;
      tick();
      n_checks++; if (IFID_PCplus4 !== 32'h4C || IFID_Instruction !== 32'h3333_3333) begin n_fail++; $display("FAIL flush_kept_ifid got=%h/%h exp=%h/%h", IFID_PCplus4, IFID_Instruction, 32'h4C, 32'h3333_3333); end
      IFIDop = IFOP_STALL; PCSrc = PCSRC_J; jPC = 32'h200;
      tick();
      n_checks++; if (mem.imem_addr !== 32'h4C || IFID_Instruction !== 32'h3333_3333) begin n_fail++; $display("FAIL stall_redir got=%h/%h exp=%h/%h", mem.imem_addr, IFID_Instruction, 32'h4C, 32'h3333_3333); end
      IFIDop = IFOP_NORMAL; PCSrc = PCSRC_SEQ;
   endtask

   task automatic test_drop();
      PCSrc = PCSRC_JR; jrPC = 32'h100; mem.imem_ack = 1'b0;
      tick();
      PCSrc = PCSRC_SEQ;
      n_checks++; if (mem.imem_addr !== 32'h4C || mem.imem_req !== 1'b1 || fetch_pending !== 1'b1) begin n_fail++; $display("FAIL drop_hold got=%h/%b/%b exp=%h/1/1", mem.imem_addr, mem.imem_req, fetch_pending, 32'h4C); end
      n_checks++; if (IFID_Instruction !== 32'h0) begin n_fail++; $display("FAIL drop_bubble got=%h exp=0", IFID_Instruction); end
      tick();
      n_checks++; if (mem.imem_addr !== 32'h4C) begin n_fail++; $display("FAIL drop_hold2 got=%h exp=%h", mem.imem_addr, 32'h4C); end
      mem.imem_ack = 1'b1; mem.imem_rdata = 32'hDEAD_BEEF;
      tick();
      mem.imem_ack = 1'b0;
      n_checks++; if (IFID_Instruction !== 32'h0) begin n_fail++; $display("FAIL drop_discard got=%h exp=0", IFID_Instruction); end
      n_checks++; if (mem.imem_addr !== 32'h100) begin n_fail++; $display("FAIL drop_newaddr got=%h exp=%h", mem.imem_addr, 32'h100); end
      tick();
      mem.imem_ack = 1'b1; mem.imem_rdata = 32'h0123_4567;
      tick();
      mem.imem_ack = 1'b0;
      n_checks++; if (IFID_PCplus4 !== 32'h104 || IFID_Instruction !== 32'h0123_4567) begin n_fail++; $display("FAIL drop_target_ifid got=%h/%h exp=%h/%h", IFID_PCplus4, IFID_Instruction, 32'h104, 32'h0123_4567); end
   endtask

   task automatic test_wrap();
      PCSrc = PCSRC_J; jPC = 32'hFFFF_FFFC; mem.imem_ack = 1'b1; mem.imem_rdata = 32'h9999_9999;
      tick();
      n_checks++; if (mem.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got=%h exp=%h", mem.imem_addr, 32'hFFFF_FFFC); end
      PCSrc = PCSRC_SEQ; mem.imem_rdata = 32'h5555_5555;
      tick();
      mem.imem_ack = 1'b0;
      n_checks++; if (IFID_PCplus4 !== 32'h0 || IFID_Instruction !== 32'h5555_5555) begin n_fail++; $display("FAIL wrap_ifid got=%h/%h exp=0/%h", IFID_PCplus4, IFID_Instruction, 32'h5555_5555); end
      n_checks++; if (mem.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr got=%h exp=0", mem.imem_addr); end
   endtask

   task automatic test_misalign();
      logic [31:0] exp_addr;
      logic        exp_exc;
`ifdef IF_EXC_EN
      exp_addr = 32'h8000_0004; exp_exc = 1'b1;
`else
      exp_addr = 32'h0000_0102; exp_exc = 1'b0;
`endif
      PCSrc = PCSRC_J; jPC = 32'h102; mem.imem_ack = 1'b1; mem.imem_rdata = 32'h6666_6666;
      tick();
      PCSrc = PCSRC_SEQ; mem.imem_ack = 1'b0;
      n_checks++; if (mem.imem_addr !== exp_addr) begin n_fail++; $display("FAIL misalign_addr got=%h exp=%h", mem.imem_addr, exp_addr); end
      n_checks++; if (if_exception !== exp_exc) begin n_fail++; $display("FAIL misalign_exc got=%b exp=%b", if_exception, exp_exc); end
      tick();
      n_checks++; if (if_exception !== 1'b0) begin n_fail++; $display("FAIL misalign_exc_pulse got=%b exp=0", if_exception); end
   endtask

   task automatic test_reset_midfetch();
      reset_n = 1'b0;
      #2;
      n_checks++; if (mem.imem_addr !== 32'h0 || fetch_pending !== 1'b1) begin n_fail++; $display("FAIL midrst_async got=%h/%b exp=0/1", mem.imem_addr, fetch_pending); end
      tick();
      reset_n = 1'b1;
      mem.imem_ack = 1'b1; mem.imem_rdata = 32'h7777_7777;
      tick();
      mem.imem_ack = 1'b0;
      n_checks++; if (IFID_PCplus4 !== 32'h4 || IFID_Instruction !== 32'h7777_7777) begin n_fail++; $display("FAIL midrst_first got=%h/%h exp=%h/%h", IFID_PCplus4, IFID_Instruction, 32'h4, 32'h7777_7777); end
   endtask

   initial begin
      reset_n = 1'b0; IFIDop = IFOP_NORMAL; PCSrc = PCSRC_SEQ; comp_true = 1'b0;
      branchPC = '0; jPC = '0; jrPC = '0;
      mem.imem_ack = 1'b0; mem.imem_rdata = '0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_flush();
      test_drop();
      test_wrap();
      test_misalign();
      test_reset_midfetch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the decode stage.
- Owns the PC register and the next-PC selection.
- Drives a req/ack instruction-memory port that tolerates variable latency.
- Holds the IF/ID pipeline register (PC+4, instruction) that decode consumes.
- Honours stall/flush codes from the hazard unit and redirects from decode (branch, j/jal, jr/jalr).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.
EXC_VECTOR, 32'h8000_0004, redirect target for a misaligned fetch (IF_EXC_EN only).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
IFIDop  in  2  0 normal, 1 flush, 2 stall, 3 treated as stall.
PCSrc  in  2  0 PC+4, 1 branch, 2 j/jal, 3 jr/jalr.
comp_true  in  1  branch condition from decode; used only when PCSrc==1.
branchPC  in  32  branch target.
jPC  in  32  j/jal target.
jrPC  in  32  jr/jalr target.
imem_req  out  1  fetch request; held high until ack.
imem_addr  out  32  fetch address; stable while imem_req is high.
imem_ack  in  1  single-cycle pulse; imem_rdata is valid in the same cycle.
imem_rdata  in  32  fetched instruction.
IFID_PCplus4  out  32  registered PC+4 of the instruction in IF/ID.
IFID_Instruction  out  32  registered instruction.
fetch_pending  out  1  high while the stage is in S_REQ or S_DROP.
if_exception  out  1  one-cycle pulse on a misaligned redirect (IF_EXC_EN only; otherwise tied 0).

Behaviour:
- Reset (reset_n low, asynchronous):
  - PC=RESET_PC, state=S_REQ.
  - IFID_PCplus4=0, IFID_Instruction=NOP_INSTR.
  - Buffer is invalid, if_exception=0.
  - imem_req=1 and imem_addr=RESET_PC from the first edge after release.
- Redirect: redirect = (PCSrc==1 && comp_true) || PCSrc==2 || PCSrc==3. The target is selected by the same codes. A redirect is honoured only when IFIDop!=2/3; during a stall it is ignored, and decode re-presents it.
- Instruction availability: avail = (S_REQ && imem_ack) || S_FULL. In S_FULL the instruction comes from the skid buffer.
- States:
  - S_REQ: imem_req=1, imem_addr=PC.
  - S_DROP: imem_req=1, imem_addr=old PC; the returning data is discarded.
  - S_FULL: imem_req=0; one instruction plus its PC is held in the skid buffer.
- Per-edge priority (highest first):
  1. Redirect honoured:
     - PC<=target, IF/ID<=bubble, buffer cleared.
     - S_REQ without ack -> S_DROP (the request cannot be aborted).
     - Otherwise -> S_REQ at the target next cycle.
  2. IFIDop==1 (flush, no redirect):
     - IF/ID<=bubble.
     - A fetch that is available is kept: from S_REQ with ack it is captured into the buffer -> S_FULL; S_FULL stays S_FULL.
     - PC is unchanged.
  3. IFIDop==2/3 (stall):
     - IF/ID and PC hold.
     - An ack in S_REQ is captured into the buffer -> S_FULL.
  4. IFIDop==0:
     - If avail: IF/ID<={PC+4, instr}, PC<=PC+4, -> S_REQ with the new address next cycle.
     - Otherwise IF/ID<=bubble.
- S_DROP: stays in S_DROP until ack; the ack data is discarded -> S_REQ with the current PC.
- Bubble = {PCplus4=0, Instruction=NOP_INSTR}.
- Arithmetic: PC+4 is 32-bit modular, so 0xFFFF_FFFC+4 = 0.
- Throughput: with zero-wait memory (ack in the same cycle as req) and no hazards, one instruction per cycle.
- Reset mid-fetch: state returns to S_REQ, and any ack in the first cycle after release belongs to the new request.

Optional Feature:
IF_EXC_EN:
- Defined: an honoured redirect whose target[1:0]!=0 sends PC to EXC_VECTOR instead of the target, and pulses if_exception for one cycle.
- Undefined: targets are used unmodified (low bits included on imem_addr), and if_exception=0.

Decomposition:
- Shared package:
  - IFIDop codes (IFOP_NORMAL/FLUSH/STALL).
  - PCSrc codes (PCSRC_SEQ/BR/J/JR).
  - Fetch state enum.
  - NOP constant.
- One sub-module: if_next_pc, combinational redirect decode and target mux (plus the misalign check). The FSM, PC, buffer and IF/ID registers stay in if_stage.

Test Plan:
1. Release reset; memory acks same-cycle with 0x2008_0001, 0x2009_0002 -> imem_addr 0,4,8 on consecutive cycles; IF/ID shows {4,0x2008_0001} then {8,0x2009_0002}.
2. Ack 0xAAAA_0000 while IFIDop=2 for 3 cycles -> IF/ID unchanged, imem_req=0 (S_FULL); IFIDop=0 -> IF/ID={PC+4,0xAAAA_0000}, next imem_addr=PC+4.
3. PCSrc=1, comp_true=1, branchPC=0x40, IFIDop=0 -> IF/ID bubble, next imem_addr=0x40; same with comp_true=0 -> sequential fetch.
4. Memory latency 3 cycles; PCSrc=3, jrPC=0x100 in cycle 1 -> req held at the old address until ack; data dropped; next req addr=0x100; IF/ID stays bubble until 0x100's instruction arrives.
5. PC=0xFFFF_FFFC, fetch completes -> IFID_PCplus4=0, next imem_addr=0.
6. With IF_EXC_EN: PCSrc=2, jPC=0x102 -> imem_addr=0x8000_0004, if_exception pulses once; without the macro imem_addr=0x102.
